// File: rtl/step_det_pkg.sv
// Shared definitions for the step edge detector: FSM encoding,
// default thresholds, debounce/settle defaults and timestamp width.
package step_det_pkg;

    typedef enum logic [2:0] {
        ST_SETTLE   = 3'd0,
        ST_LOW      = 3'd1,
        ST_RISE_CHK = 3'd2,
        ST_HIGH     = 3'd3,
        ST_FALL_CHK = 3'd4
    } det_state_t;

    localparam int                 TS_W         = 32;
    localparam logic signed [15:0] DEF_HI_TH    = 16'sd1000;
    localparam logic signed [15:0] DEF_LO_TH    = 16'sd500;
    localparam int                 DEF_DEBOUNCE = 4;
    localparam int                 DEF_SETTLE   = 16;

endpackage

// File: rtl/step_evt_buf.sv
// One-entry event buffer with valid/ready handshake and a sticky
// overrun flag for events that arrive while the entry is still held.
module step_evt_buf
    import step_det_pkg::*;
(
    input  logic            pClk,
    input  logic            pRst,
    input  logic            pLoad,
    input  logic            pLoadRising,
    input  logic [15:0]     pLoadLevel,
    input  logic [TS_W-1:0] pLoadTime,
    input  logic            pEvtReady,
    output logic            pEvtValid,
    output logic            pEvtRising,
    output logic [15:0]     pEvtLevel,
    output logic [TS_W-1:0] pEvtTime,
    output logic            pOverrun
);

    logic            valid_r;
    logic            rising_r;
    logic [15:0]     level_r;
    logic [TS_W-1:0] time_r;
    logic            overrun_r;
    logic            drain_s;
    logic            accept_s;

    // Handshake decode: a load is accepted when the entry is empty or leaving now.
    always_comb begin
        drain_s  = valid_r & pEvtReady;
        accept_s = pLoad & (~valid_r | drain_s);
    end

    // Entry storage; payload only changes when a new event is accepted.
    always_ff @(posedge pClk) begin
        if (!pRst) begin
            valid_r   <= 1'b0;
            rising_r  <= 1'b0;
            level_r   <= 16'd0;
            time_r    <= {TS_W{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            if (accept_s) begin
                valid_r  <= 1'b1;
                rising_r <= pLoadRising;
                level_r  <= pLoadLevel;
                time_r   <= pLoadTime;
            end else if (drain_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            if (pLoad && !accept_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign pEvtValid  = valid_r;
    assign pEvtRising = rising_r;
    assign pEvtLevel  = level_r;
    assign pEvtTime   = time_r;
    assign pOverrun   = overrun_r;

endmodule

// File: rtl/step_edge_detect.sv
// Hysteresis step detector: debounced threshold crossings of a filtered
// sample stream are reported as timestamped events through a one-entry buffer.
module step_edge_detect
    import step_det_pkg::*;
#(
    parameter logic signed [15:0] HI_TH    = DEF_HI_TH,
    parameter logic signed [15:0] LO_TH    = DEF_LO_TH,
    parameter int                 DEBOUNCE = DEF_DEBOUNCE,
    parameter int                 SETTLE   = DEF_SETTLE
) (
    input  logic               pClk,
    input  logic               pRst,
    input  logic signed [15:0] pFilterIn,
    output logic               pEvtValid,
    input  logic               pEvtReady,
    output logic               pEvtRising,
    output logic [15:0]        pEvtLevel,
    output logic [TS_W-1:0]    pEvtTime,
    output logic               pLevelHigh,
    output logic               pOverrun
);

    if (LO_TH >= HI_TH) begin : g_bad_th
        $error("step_edge_detect: LO_TH must be below HI_TH");
    end
    if ((DEBOUNCE < 1) || (DEBOUNCE > 255)) begin : g_bad_deb
        $error("step_edge_detect: DEBOUNCE must be 1..255");
    end
    if ((SETTLE < 1) || (SETTLE > 65535)) begin : g_bad_settle
        $error("step_edge_detect: SETTLE must be 1..65535");
    end

    localparam logic [7:0]  DEB_LAST    = 8'(DEBOUNCE - 1);
    localparam logic        DEB_ONE     = (DEBOUNCE == 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);

    det_state_t      state_r;
    logic [15:0]     settle_cnt_r;
    logic [7:0]      deb_cnt_r;
    logic [TS_W-1:0] ts_r;
    logic [15:0]     cap_level_r;
    logic [TS_W-1:0] cap_time_r;
    logic            level_high_r;

    logic            hi_q_s;
    logic            lo_q_s;
    logic            rise_commit_s;
    logic            fall_commit_s;
    logic [15:0]     evt_level_s;
    logic [TS_W-1:0] evt_time_s;

    // Qualify the sample and decide whether this edge commits a transition.
    always_comb begin
        hi_q_s        = (pFilterIn >= HI_TH);
        lo_q_s        = (pFilterIn <= LO_TH);
        rise_commit_s = 1'b0;
        fall_commit_s = 1'b0;
        evt_level_s   = cap_level_r;
        evt_time_s    = cap_time_r;
        case (state_r)
            ST_LOW: begin
                if (hi_q_s && DEB_ONE) begin
                    rise_commit_s = 1'b1;
                    evt_level_s   = pFilterIn;
                    evt_time_s    = ts_r;
                end else begin
                    rise_commit_s = 1'b0;
                end
            end
            ST_RISE_CHK: begin
                if (hi_q_s && (deb_cnt_r == DEB_LAST)) begin
                    rise_commit_s = 1'b1;
                end else begin
                    rise_commit_s = 1'b0;
                end
            end
            ST_HIGH: begin
                if (lo_q_s && DEB_ONE) begin
                    fall_commit_s = 1'b1;
                    evt_level_s   = pFilterIn;
                    evt_time_s    = ts_r;
                end else begin
                    fall_commit_s = 1'b0;
                end
            end
            ST_FALL_CHK: begin
                if (lo_q_s && (deb_cnt_r == DEB_LAST)) begin
                    fall_commit_s = 1'b1;
                end else begin
                    fall_commit_s = 1'b0;
                end
            end
            default: begin
                rise_commit_s = 1'b0;
                fall_commit_s = 1'b0;
            end
        endcase
    end

    // Detector FSM, settle/debounce counters, capture registers and timestamp.
    always_ff @(posedge pClk) begin
        if (!pRst) begin
            state_r      <= ST_SETTLE;
            settle_cnt_r <= 16'd0;
            deb_cnt_r    <= 8'd0;
            ts_r         <= {TS_W{1'b0}};
            cap_level_r  <= 16'd0;
            cap_time_r   <= {TS_W{1'b0}};
            level_high_r <= 1'b0;
        end else begin
            ts_r <= ts_r + 32'd1;
            case (state_r)
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        settle_cnt_r <= 16'd0;
                        state_r      <= hi_q_s ? ST_HIGH : ST_LOW;
                        level_high_r <= hi_q_s;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 16'd1;
                    end
                end
                ST_LOW: begin
                    if (rise_commit_s) begin
                        state_r      <= ST_HIGH;
                        level_high_r <= 1'b1;
                        deb_cnt_r    <= 8'd0;
                    end else if (hi_q_s) begin
                        state_r     <= ST_RISE_CHK;
                        deb_cnt_r   <= 8'd1;
                        cap_level_r <= pFilterIn;
                        cap_time_r  <= ts_r;
                    end else begin
                        state_r <= ST_LOW;
                    end
                end
                ST_RISE_CHK: begin
                    if (rise_commit_s) begin
                        state_r      <= ST_HIGH;
                        level_high_r <= 1'b1;
                        deb_cnt_r    <= 8'd0;
                    end else if (hi_q_s) begin
                        deb_cnt_r <= deb_cnt_r + 8'd1;
                    end else begin
                        state_r   <= ST_LOW;
                        deb_cnt_r <= 8'd0;
                    end
                end
                ST_HIGH: begin
                    if (fall_commit_s) begin
                        state_r      <= ST_LOW;
                        level_high_r <= 1'b0;
                        deb_cnt_r    <= 8'd0;
                    end else if (lo_q_s) begin
                        state_r     <= ST_FALL_CHK;
                        deb_cnt_r   <= 8'd1;
                        cap_level_r <= pFilterIn;
                        cap_time_r  <= ts_r;
                    end else begin
                        state_r <= ST_HIGH;
                    end
                end
                ST_FALL_CHK: begin
                    if (fall_commit_s) begin
                        state_r      <= ST_LOW;
                        level_high_r <= 1'b0;
                        deb_cnt_r    <= 8'd0;
                    end else if (lo_q_s) begin
                        deb_cnt_r <= deb_cnt_r + 8'd1;
                    end else begin
                        state_r   <= ST_HIGH;
                        deb_cnt_r <= 8'd0;
                    end
                end
                default: begin
                    state_r      <= ST_SETTLE;
                    settle_cnt_r <= 16'd0;
                    deb_cnt_r    <= 8'd0;
                    level_high_r <= 1'b0;
                end
            endcase
        end
    end

    assign pLevelHigh = level_high_r;

    step_evt_buf u_evt_buf (
        .pClk        (pClk),
        .pRst        (pRst),
        .pLoad       (rise_commit_s | fall_commit_s),
        .pLoadRising (rise_commit_s),
        .pLoadLevel  (evt_level_s),
        .pLoadTime   (evt_time_s),
        .pEvtReady   (pEvtReady),
        .pEvtValid   (pEvtValid),
        .pEvtRising  (pEvtRising),
        .pEvtLevel   (pEvtLevel),
        .pEvtTime    (pEvtTime),
        .pOverrun    (pOverrun)
    );

endmodule

// File: tb/tb_step_edge_detect.sv
// Directed self-checking bench for step_edge_detect (default parameters).
module tb_step_edge_detect;

    logic               pClk = 1'b0;
    logic               pRst;
    logic signed [15:0] pFilterIn;
    logic               pEvtValid;
    logic               pEvtReady;
    logic               pEvtRising;
    logic [15:0]        pEvtLevel;
    logic [31:0]        pEvtTime;
    logic               pLevelHigh;
    logic               pOverrun;

    int n_checks = 0;
    int n_fail   = 0;
    int vcnt     = 0;

    step_edge_detect dut (
        .pClk       (pClk),
        .pRst       (pRst),
        .pFilterIn  (pFilterIn),
        .pEvtValid  (pEvtValid),
        .pEvtReady  (pEvtReady),
        .pEvtRising (pEvtRising),
        .pEvtLevel  (pEvtLevel),
        .pEvtTime   (pEvtTime),
        .pLevelHigh (pLevelHigh),
        .pOverrun   (pOverrun)
    );

    always #5 pClk = ~pClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pClk);
            #1;
        end
    endtask

    // Advance n cycles, counting cycles in which an event is presented.
    task automatic tick_cnt(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pClk);
            #1;
            if (pEvtValid === 1'b1) vcnt++;
        end
    endtask

    // After this returns the current cycle has timestamp 0.
    task automatic do_reset(input logic signed [15:0] v);
        pRst      = 1'b0;
        pFilterIn = v;
        tick(2);
        pRst = 1'b1;
    endtask

    initial begin
        pEvtReady = 1'b1;

        // Reset state and settle into HIGH with a constant 2000.
        pRst      = 1'b0;
        pFilterIn = 16'sd2000;
        tick(2);
        chk("rst_valid",   {31'd0, pEvtValid},  32'd0);
        chk("rst_rising",  {31'd0, pEvtRising}, 32'd0);
        chk("rst_level",   {16'd0, pEvtLevel},  32'd0);
        chk("rst_time",    pEvtTime,            32'd0);
        chk("rst_lvlhigh", {31'd0, pLevelHigh}, 32'd0);
        chk("rst_overrun", {31'd0, pOverrun},   32'd0);
        pRst = 1'b1;
        vcnt = 0;
        tick_cnt(15);
        chk("settle_lvl15", {31'd0, pLevelHigh}, 32'd0);
        tick_cnt(1);
        chk("settle_lvl16", {31'd0, pLevelHigh}, 32'd1);
        tick_cnt(20);
        chk("settle_noevt", vcnt, 32'd0);

        // Rising step at T=16, debounced 4 cycles, delivered at once.
        do_reset(16'sd0);
        tick(16);
        chk("low_lvl", {31'd0, pLevelHigh}, 32'd0);
        pFilterIn = 16'sd1200;
        tick(3);
        chk("rise_early", {31'd0, pEvtValid}, 32'd0);
        tick(1);
        chk("rise_valid",  {31'd0, pEvtValid},  32'd1);
        chk("rise_dir",    {31'd0, pEvtRising}, 32'd1);
        chk("rise_level",  {16'd0, pEvtLevel},  32'd1200);
        chk("rise_time",   pEvtTime,            32'd16);
        chk("rise_lvlhi",  {31'd0, pLevelHigh}, 32'd1);
        tick(1);
        chk("rise_pulse", {31'd0, pEvtValid}, 32'd0);

        // Mid-band samples from HIGH do nothing; then fall at 400 from ts 71.
        pFilterIn = 16'sd700;
        vcnt = 0;
        tick_cnt(50);
        chk("mid_noevt", vcnt, 32'd0);
        chk("mid_lvlhi", {31'd0, pLevelHigh}, 32'd1);
        pFilterIn = 16'sd400;
        tick(3);
        chk("fall_early", {31'd0, pEvtValid}, 32'd0);
        tick(1);
        chk("fall_valid", {31'd0, pEvtValid},  32'd1);
        chk("fall_dir",   {31'd0, pEvtRising}, 32'd0);
        chk("fall_level", {16'd0, pEvtLevel},  32'd400);
        chk("fall_time",  pEvtTime,            32'd71);
        chk("fall_lvl",   {31'd0, pLevelHigh}, 32'd0);

        // Short high burst (3 cycles) aborts; a later full burst commits.
        do_reset(16'sd0);
        tick(16);
        pFilterIn = 16'sd1200;
        tick(3);
        pFilterIn = 16'sd0;
        vcnt = 0;
        tick_cnt(12);
        chk("short_noevt", vcnt, 32'd0);
        chk("short_lvl",   {31'd0, pLevelHigh}, 32'd0);
        pFilterIn = 16'sd1200;
        tick(4);
        chk("after_abort_valid", {31'd0, pEvtValid}, 32'd1);
        chk("after_abort_time",  pEvtTime,           32'd31);

        // Buffer full, no drain: falling commit dropped, overrun set.
        do_reset(16'sd0);
        pEvtReady = 1'b0;
        tick(16);
        pFilterIn = 16'sd1200;
        tick(4);
        chk("ovr_first_valid", {31'd0, pEvtValid}, 32'd1);
        pFilterIn = 16'sd0;
        tick(4);
        chk("ovr_valid",   {31'd0, pEvtValid},  32'd1);
        chk("ovr_dir",     {31'd0, pEvtRising}, 32'd1);
        chk("ovr_level",   {16'd0, pEvtLevel},  32'd1200);
        chk("ovr_time",    pEvtTime,            32'd16);
        chk("ovr_flag",    {31'd0, pOverrun},   32'd1);
        chk("ovr_lvl",     {31'd0, pLevelHigh}, 32'd0);
        pEvtReady = 1'b1;
        tick(1);
        chk("ovr_drained", {31'd0, pEvtValid}, 32'd0);
        chk("ovr_sticky",  {31'd0, pOverrun},  32'd1);

        // Commit on the same edge as a drain: new event replaces, no overrun.
        do_reset(16'sd0);
        chk("rst_clr_ovr", {31'd0, pOverrun}, 32'd0);
        pEvtReady = 1'b0;
        tick(16);
        pFilterIn = 16'sd1200;
        tick(4);
        pFilterIn = 16'sd100;
        tick(3);
        pEvtReady = 1'b1;
        tick(1);
        chk("swap_valid", {31'd0, pEvtValid},  32'd1);
        chk("swap_dir",   {31'd0, pEvtRising}, 32'd0);
        chk("swap_level", {16'd0, pEvtLevel},  32'd100);
        chk("swap_time",  pEvtTime,            32'd20);
        chk("swap_ovr",   {31'd0, pOverrun},   32'd0);
        tick(1);
        chk("swap_drain", {31'd0, pEvtValid}, 32'd0);

        // Reset during a rising check (count 2): nothing emitted, time restarts.
        do_reset(16'sd0);
        tick(16);
        pFilterIn = 16'sd1200;
        tick(2);
        pRst = 1'b0;
        tick(1);
        chk("midrst_valid", {31'd0, pEvtValid},  32'd0);
        chk("midrst_lvl",   {31'd0, pLevelHigh}, 32'd0);
        pRst      = 1'b1;
        pFilterIn = 16'sd0;
        vcnt = 0;
        tick_cnt(16);
        chk("midrst_noevt", vcnt, 32'd0);
        pFilterIn = 16'sd1200;
        tick(4);
        chk("midrst_new_valid", {31'd0, pEvtValid}, 32'd1);
        chk("midrst_new_time",  pEvtTime,           32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
